// File: rtl/run_control.sv
// CPU run/halt/single-step sequencer: arbitrates boot, microcode halt, debug commands
// and the halt/continue buttons, and drives the CPU reset and run-enable.
module run_control #(
   parameter int BOOT_DELAY = 16,
   parameter int CNT_W      = 16,
   parameter int AUTO_RUN   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             boot,
   input  logic             halt,
   input  logic             cont,
   input  logic             ucode_halt,
   input  logic             dbg_valid,
   input  logic [1:0]       dbg_op,
   input  logic [CNT_W-1:0] dbg_count,
   output logic             dbg_ready,
   output logic             cpu_reset,
   output logic             cpu_run,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] steps_left
);

   typedef enum logic [1:0] {
      S_HOLD   = 2'd0,
      S_HALTED = 2'd1,
      S_RUN    = 2'd2,
      S_STEP   = 2'd3
   } state_t;

   localparam int HOLD_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BOOT_DELAY - 1);

   localparam logic [1:0] OP_HALT  = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_STEP  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [1:0] CAUSE_NONE   = 2'b00;
   localparam logic [1:0] CAUSE_BUTTON = 2'b01;
   localparam logic [1:0] CAUSE_DEBUG  = 2'b10;
   localparam logic [1:0] CAUSE_UCODE  = 2'b11;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]        halt_cause_q, halt_cause_d;
   logic [CNT_W-1:0]  steps_left_q, steps_left_d;
   logic              halt_prev_q, halt_prev_d;
   logic              cont_prev_q, cont_prev_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              cpu_run_q, cpu_run_d;
   logic              halted_q, halted_d;
   logic              dbg_ready_q, dbg_ready_d;

   logic              halt_edge_s;
   logic              cont_edge_s;
   logic              cmd_s;
   logic [CNT_W-1:0]  steps_dec_s;

   // Next-state logic: one winning event per cycle, lower-priority events dropped
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      halt_cause_d = halt_cause_q;
      steps_left_d = steps_left_q;
      halt_prev_d  = halt;
      cont_prev_d  = cont;
      halt_edge_s  = halt & ~halt_prev_q;
      cont_edge_s  = cont & ~cont_prev_q;
      cmd_s        = dbg_valid & dbg_ready_q;
      steps_dec_s  = (steps_left_q != '0) ? (steps_left_q - CNT_W'(1)) : steps_left_q;

      if (boot) begin
         state_d      = S_HOLD;
         hold_cnt_d   = '0;
         steps_left_d = '0;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  hold_cnt_d = '0;
                  if (AUTO_RUN != 0) begin
                     state_d = S_RUN;
                  end else begin
                     state_d      = S_HALTED;
                     halt_cause_d = CAUSE_NONE;
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end
            S_RUN: begin
               if (ucode_halt) begin
                  state_d      = S_HALTED;
                  halt_cause_d = CAUSE_UCODE;
               end else if (cmd_s) begin
                  case (dbg_op)
                     OP_HALT: begin
                        state_d      = S_HALTED;
                        halt_cause_d = CAUSE_DEBUG;
                     end
                     OP_CLEAR: halt_cause_d = CAUSE_NONE;
                     default:  state_d = S_RUN;
                  endcase
               end else if (halt_edge_s) begin
                  state_d      = S_HALTED;
                  halt_cause_d = CAUSE_BUTTON;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_HALTED: begin
               if (cmd_s) begin
                  case (dbg_op)
                     OP_RUN: state_d = S_RUN;
                     OP_STEP: begin
                        if (dbg_count != '0) begin
                           state_d      = S_STEP;
                           steps_left_d = dbg_count;
                        end else begin
                           state_d = S_HALTED;
                        end
                     end
                     OP_CLEAR: halt_cause_d = CAUSE_NONE;
                     default:  state_d = S_HALTED;
                  endcase
               end else if (halt_edge_s) begin
                  // already halted: the edge wins the cycle but changes nothing
                  state_d = S_HALTED;
               end else if (cont_edge_s) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_HALTED;
               end
            end
            S_STEP: begin
               steps_left_d = steps_dec_s;
               if (ucode_halt) begin
                  state_d      = S_HALTED;
                  halt_cause_d = CAUSE_UCODE;
               end else if (halt_edge_s) begin
                  state_d      = S_HALTED;
                  halt_cause_d = CAUSE_BUTTON;
               end else if (steps_dec_s == '0) begin
                  state_d      = S_HALTED;
                  halt_cause_d = CAUSE_DEBUG;
               end else begin
                  state_d = S_STEP;
               end
            end
            default: state_d = S_HOLD;
         endcase
      end

      cpu_reset_d = (state_d == S_HOLD);
      cpu_run_d   = (state_d == S_RUN) || (state_d == S_STEP);
      halted_d    = (state_d == S_HALTED);
      dbg_ready_d = (state_d == S_HALTED) || (state_d == S_RUN);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_HOLD;
         hold_cnt_q   <= '0;
         halt_cause_q <= CAUSE_NONE;
         steps_left_q <= '0;
         halt_prev_q  <= 1'b0;
         cont_prev_q  <= 1'b0;
         cpu_reset_q  <= 1'b1;
         cpu_run_q    <= 1'b0;
         halted_q     <= 1'b0;
         dbg_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         halt_cause_q <= halt_cause_d;
         steps_left_q <= steps_left_d;
         halt_prev_q  <= halt_prev_d;
         cont_prev_q  <= cont_prev_d;
         cpu_reset_q  <= cpu_reset_d;
         cpu_run_q    <= cpu_run_d;
         halted_q     <= halted_d;
         dbg_ready_q  <= dbg_ready_d;
      end
   end

   assign dbg_ready  = dbg_ready_q;
   assign cpu_reset  = cpu_reset_q;
   assign cpu_run    = cpu_run_q;
   assign halted     = halted_q;
   assign halt_cause = halt_cause_q;
   assign steps_left = steps_left_q;

endmodule

// File: tb/tb_run_control.sv
// Self-checking bench for run_control: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_run_control;

   localparam int BOOT_DELAY = 16;
   localparam int CNT_W      = 16;

   localparam int M_HOLD   = 0;
   localparam int M_HALTED = 1;
   localparam int M_RUN    = 2;
   localparam int M_STEP   = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             boot = 1'b0;
   logic             halt = 1'b0;
   logic             cont = 1'b0;
   logic             ucode_halt = 1'b0;
   logic             dbg_valid = 1'b0;
   logic [1:0]       dbg_op = 2'b00;
   logic [CNT_W-1:0] dbg_count = '0;
   logic             dbg_ready;
   logic             cpu_reset;
   logic             cpu_run;
   logic             halted;
   logic [1:0]       halt_cause;
   logic [CNT_W-1:0] steps_left;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // model: current (after last edge) and next values
   int m_st, m_el, m_cause, m_steps, m_hp, m_cp;
   int n_st, n_el, n_cause, n_steps, n_hp, n_cp;

   run_control #(.BOOT_DELAY(BOOT_DELAY), .CNT_W(CNT_W), .AUTO_RUN(0)) dut (
      .clk(clk), .reset(reset), .boot(boot), .halt(halt), .cont(cont),
      .ucode_halt(ucode_halt), .dbg_valid(dbg_valid), .dbg_op(dbg_op),
      .dbg_count(dbg_count), .dbg_ready(dbg_ready), .cpu_reset(cpu_reset),
      .cpu_run(cpu_run), .halted(halted), .halt_cause(halt_cause),
      .steps_left(steps_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural rules: pick the single winning event of the cycle, then apply it
   task automatic model_advance();
      bit hedge, cedge;
      int rem;
      hedge   = halt && (m_hp == 0);
      cedge   = cont && (m_cp == 0);
      n_st    = m_st; n_el = m_el; n_cause = m_cause; n_steps = m_steps;
      n_hp    = int'(halt); n_cp = int'(cont);
      if (reset) begin
         n_st = M_HOLD; n_el = 0; n_cause = 0; n_steps = 0; n_hp = 0; n_cp = 0;
      end else if (boot) begin
         n_st = M_HOLD; n_el = 0; n_steps = 0;
      end else if (m_st == M_HOLD) begin
         n_el = m_el + 1;
         if (n_el == BOOT_DELAY) begin
            n_st = M_HALTED; n_cause = 0; n_el = 0;
         end
      end else if (m_st == M_STEP) begin
         rem = (m_steps > 0) ? m_steps - 1 : 0;
         n_steps = rem;
         if (ucode_halt)    begin n_st = M_HALTED; n_cause = 3; end
         else if (hedge)    begin n_st = M_HALTED; n_cause = 1; end
         else if (rem == 0) begin n_st = M_HALTED; n_cause = 2; end
      end else begin
         if (m_st == M_RUN && ucode_halt) begin
            n_st = M_HALTED; n_cause = 3;
         end else if (dbg_valid) begin
            if (dbg_op == 2'd0 && m_st == M_RUN) begin n_st = M_HALTED; n_cause = 2; end
            if (dbg_op == 2'd1) n_st = M_RUN;
            if (dbg_op == 2'd2 && m_st == M_HALTED && dbg_count != 0) begin
               n_st = M_STEP; n_steps = int'(dbg_count);
            end
            if (dbg_op == 2'd3) n_cause = 0;
         end else if (hedge) begin
            if (m_st == M_RUN) begin n_st = M_HALTED; n_cause = 1; end
         end else if (cedge) begin
            n_st = M_RUN;
         end
      end
   endtask

   // One clock with the currently driven inputs; model commits at the edge
   task automatic step();
      model_advance();
      @(posedge clk);
      m_st = n_st; m_el = n_el; m_cause = n_cause; m_steps = n_steps;
      m_hp = n_hp; m_cp = n_cp;
      #1;
   endtask

   // Compare every output against the model each cycle
   always @(negedge clk) begin
      if (chk_en) begin
         check("cpu_reset", 32'(cpu_reset), 32'(m_st == M_HOLD));
         check("cpu_run", 32'(cpu_run), 32'(m_st == M_RUN || m_st == M_STEP));
         check("halted", 32'(halted), 32'(m_st == M_HALTED));
         check("dbg_ready", 32'(dbg_ready), 32'(m_st == M_HALTED || m_st == M_RUN));
         check("halt_cause", 32'(halt_cause), 32'(m_cause));
         check("steps_left", 32'(steps_left), 32'(m_steps));
      end
   end

   task automatic dbg_cmd(input logic [1:0] op, input int cnt);
      dbg_valid = 1'b1; dbg_op = op; dbg_count = CNT_W'(cnt);
      step();
      dbg_valid = 1'b0;
   endtask

   initial begin
      int cnt;
      // reset: cpu_reset held exactly BOOT_DELAY cycles
      step();
      chk_en = 1'b1;
      step();
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_dbg_ready", 32'(dbg_ready), 32'd0);
      cnt = int'(cpu_reset);
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (!cpu_reset) break;
         cnt++;
      end
      check("boot_hold_len", 32'(cnt), 32'd16);
      check("boot_halted", 32'(halted), 32'd1);
      check("boot_cause", 32'(halt_cause), 32'd0);
      check("boot_ready", 32'(dbg_ready), 32'd1);

      // STEP 3: steps_left 3,2,1 with cpu_run, then 0 halted cause 10
      dbg_cmd(2'b10, 3);
      for (int i = 0; i < 4; i++) begin
         check("step3_left", 32'(steps_left), 32'(3 - i));
         check("step3_run", 32'(cpu_run), 32'(i < 3));
         if (i < 3) step();
      end
      check("step3_cause", 32'(halt_cause), 32'd2);

      // RUN, then ucode_halt and debug HALT together
      dbg_cmd(2'b01, 0);
      check("run_run", 32'(cpu_run), 32'd1);
      check("both_ready", 32'(dbg_ready), 32'd1);
      ucode_halt = 1'b1;
      dbg_cmd(2'b00, 0);
      ucode_halt = 1'b0;
      check("both_halted", 32'(halted), 32'd1);
      check("both_cause", 32'(halt_cause), 32'd3);

      // cont held for 50 clocks gives one RUN; halt edge then CLEAR
      cont = 1'b1;
      step();
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         cnt += int'(cpu_run);
      end
      check("cont_run_cycles", 32'(cnt), 32'd50);
      halt = 1'b1;
      step();
      check("hedge_halted", 32'(halted), 32'd1);
      check("hedge_cause", 32'(halt_cause), 32'd1);
      halt = 1'b0; cont = 1'b0;
      dbg_cmd(2'b11, 0);
      check("clear_cause", 32'(halt_cause), 32'd0);

      // STEP with count 0 is a no-op
      check("step0_ready", 32'(dbg_ready), 32'd1);
      dbg_cmd(2'b10, 0);
      check("step0_run", 32'(cpu_run), 32'd0);
      step();
      check("step0_halted", 32'(halted), 32'd1);

      // STEP 100 interrupted by boot on the 5th step
      dbg_cmd(2'b10, 100);
      for (int i = 0; i < 4; i++) step();
      check("s100_left5", 32'(steps_left), 32'd96);
      boot = 1'b1;
      step();
      boot = 1'b0;
      check("s100_left_boot", 32'(steps_left), 32'd0);
      cnt = int'(cpu_reset);
      for (int i = 0; i < 100; i++) begin
         step();
         if (!cpu_reset) break;
         cnt++;
      end
      check("s100_hold_len", 32'(cnt), 32'd16);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         reset      = ($urandom_range(0, 599) == 0);
         boot       = ($urandom_range(0, 249) == 0);
         ucode_halt = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 9) == 0) halt = ~halt;
         if ($urandom_range(0, 7) == 0) cont = ~cont;
         dbg_valid  = ($urandom_range(0, 3) == 0);
         dbg_op     = 2'($urandom_range(0, 3));
         dbg_count  = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom_range(0, 300))
                                                   : CNT_W'($urandom_range(0, 6));
         step();
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
